// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and default sizing for the SPI transfer controller
package spi_pkg;
   localparam int DATA_W_DEF  = 8;
   localparam int CLK_DIV_DEF = 4;
   typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;
endpackage

// File: rtl/spi_xfer_ctrl_clk_gen.sv
// spi_clk_gen: half-period divider (run/xfer/idle flags, cpol levels, current sclk in; hp_end, lead_edge, trail_edge, sclk_nxt out)
module spi_clk_gen import spi_pkg::*; #(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk_ext,
   input  logic reset_n,
   input  logic run,
   input  logic xfer,
   input  logic idle,
   input  logic cpol_in,
   input  logic cpol,
   input  logic sclk,
   output logic hp_end,
   output logic lead_edge,
   output logic trail_edge,
   output logic sclk_nxt
);
   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] HP_MAX = CW'(CLK_DIV - 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk_ext or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= (!run || hp_end) ? '0 : cnt + 1'b1;
   always_comb begin
      hp_end     = run && cnt == HP_MAX;
      lead_edge  = xfer && hp_end && sclk == cpol;
      trail_edge = xfer && hp_end && sclk != cpol;
      sclk_nxt   = idle ? cpol_in : xfer ? sclk ^ hp_end : cpol;
   end
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master for one DATA_W transfer (start/CPOL/CPHA/tx_data in; SCLK/MOSI/CS_n/MISO serial; shift/busy/done/rx_data status)
module spi_xfer_ctrl import spi_pkg::*; #(
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic              clk_ext,
   input  logic              reset_n,
   input  logic              CPOL,
   input  logic              CPHA,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic              CS_n,
   output logic              shift,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data
);
   localparam int EW = $clog2(2 * DATA_W + 1);
   localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);
   state_t state, state_nxt;
   logic rdy, cpol_q, cpha_q, run, xfer, idle, accept;
   logic hp_end, lead_edge, trail_edge, sclk_nxt, tx_adv, rx_smp;
   logic [EW-1:0] ecnt;
   logic [DATA_W-1:0] tx_sr, rx_sr;
   assign idle   = state == IDLE;
   assign xfer   = state == XFER;
   assign run    = state inside {LEAD, XFER, TRAIL};
   // rdy holds off acceptance for the first edge after reset release
   assign accept = idle && start && rdy;
   // CPHA=1 already shows the first bit in LEAD, so edge 1 does not advance
   assign tx_adv = cpha_q ? lead_edge && ecnt != '0 : trail_edge && ecnt != E_LAST;
   assign rx_smp = cpha_q ? trail_edge : lead_edge;
   assign MOSI   = run ? tx_sr[DATA_W-1] : 1'b1;
   assign CS_n   = !run;
   assign busy   = run;
   assign shift  = xfer;
   assign done   = state == DONE;
   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk_ext    (clk_ext),
      .reset_n    (reset_n),
      .run        (run),
      .xfer       (xfer),
      .idle       (idle),
      .cpol_in    (CPOL),
      .cpol       (cpol_q),
      .sclk       (SCLK),
      .hp_end     (hp_end),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .sclk_nxt   (sclk_nxt)
   );
   always_ff @(posedge clk_ext or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = accept                                 ? LEAD  :
                  state == LEAD && hp_end                ? XFER  :
                  xfer && hp_end && ecnt == E_LAST       ? TRAIL :
                  state == TRAIL && hp_end               ? DONE  :
                  state == DONE                          ? IDLE  : state;
   end
   always_ff @(posedge clk_ext or negedge reset_n)
      if (!reset_n) begin
         rdy     <= 1'b0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         ecnt    <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         rx_data <= '0;
         SCLK    <= 1'b1;
      end else begin
         rdy  <= 1'b1;
         SCLK <= sclk_nxt;
         if (accept) begin
            cpol_q <= CPOL;
            cpha_q <= CPHA;
            tx_sr  <= tx_data;
            rx_sr  <= '0;
            ecnt   <= '0;
         end else begin
            if (xfer && hp_end) ecnt <= ecnt + 1'b1;
            if (tx_adv) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            if (rx_smp) rx_sr <= {rx_sr[DATA_W-2:0], MISO};
            if (state == TRAIL && hp_end) rx_data <= rx_sr;
         end
      end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed and randomized transfers checked against a bench-side SPI slave model
module tb_spi_xfer_ctrl;
   logic clk_ext = 1'b0, reset_n = 1'b0;
   logic CPOL = 1'b1, CPHA = 1'b0, start = 1'b0, loop = 1'b0, miso_drv = 1'b0;
   logic [7:0] tx_data = '0;
   logic MISO, SCLK, MOSI, CS_n, shift, busy, done;
   logic [7:0] rx_data;
   logic CPOL2 = 1'b0, CPHA2 = 1'b0, start2 = 1'b0, MISO2 = 1'b0;
   logic [7:0] tx2 = 8'hFF;
   logic SCLK2, MOSI2, CS_n2, shift2, busy2, done2;
   logic [7:0] rx2;
   int checks = 0, errors = 0;
   always #5 clk_ext = ~clk_ext;
   assign MISO = loop ? MOSI : miso_drv;
   spi_xfer_ctrl u_dut (
      .clk_ext(clk_ext), .reset_n(reset_n), .CPOL(CPOL), .CPHA(CPHA), .start(start),
      .tx_data(tx_data), .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n),
      .shift(shift), .busy(busy), .done(done), .rx_data(rx_data)
   );
   spi_xfer_ctrl #(.CLK_DIV(2)) u_dut2 (
      .clk_ext(clk_ext), .reset_n(reset_n), .CPOL(CPOL2), .CPHA(CPHA2), .start(start2),
      .tx_data(tx2), .MISO(MISO2), .SCLK(SCLK2), .MOSI(MOSI2), .CS_n(CS_n2),
      .shift(shift2), .busy(busy2), .done(done2), .rx_data(rx2)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // One transfer on u_dut with the bench acting as slave; cycle c = c-th falling edge after the start edge.
   task automatic run_xfer(input string tag, input logic pol, input logic pha, input logic [7:0] tx,
                           input logic [7:0] slv, input logic lp, input logic scr, input logic [7:0] scr_tx);
      int k, lat, gap_bad, t_last, j;
      logic [7:0] cap;
      logic prev;
      k = 0; lat = -1; gap_bad = 0; t_last = 0; cap = '0;
      CPOL = pol; CPHA = pha; loop = lp; miso_drv = slv[7];
      @(negedge clk_ext);
      prev = SCLK;
      start = 1'b1; tx_data = tx;
      for (int c = 1; c <= 200 && lat < 0; c++) begin
         @(negedge clk_ext);
         if (c == 1) begin
            start = 1'b0;
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_csn"}, CS_n, 0);
            chk({tag, "_mosi0"}, MOSI, tx[7]);
            chk({tag, "_lead_sclk"}, SCLK, pol);
            if (scr) begin tx_data = scr_tx; CPOL = ~pol; CPHA = ~pha; end
         end
         if (c == 5) chk({tag, "_shift"}, shift, 1);
         if (SCLK !== prev) begin
            k++;
            if (k > 1 && c - t_last != 4) gap_bad++;
            t_last = c;
            j = pha ? (k - 1) / 2 : k / 2;
            if ((k % 2 == 1) != pha) cap = {cap[6:0], MOSI};
            else if (j < 8) miso_drv = slv[7 - j];
         end
         prev = SCLK;
         if (done) lat = c;
      end
      chk({tag, "_latency"}, lat, 73);
      chk({tag, "_edges"}, k, 16);
      chk({tag, "_gaps"}, gap_bad, 0);
      chk({tag, "_mosi_bits"}, cap, tx);
      chk({tag, "_rx"}, rx_data, lp ? tx : slv);
      chk({tag, "_done_sclk"}, SCLK, pol);
      chk({tag, "_done_csn"}, CS_n, 1);
      chk({tag, "_done_busy"}, busy, 0);
      CPOL = pol; CPHA = pha; loop = 1'b0;
      @(negedge clk_ext);
      chk({tag, "_done_pulse"}, done, 0);
   endtask
   task automatic run2(input string tag, input logic miso, input logic [7:0] exp_rx);
      int k, lat, gap_bad, t_last;
      logic prev;
      k = 0; lat = -1; gap_bad = 0; t_last = 0;
      MISO2 = miso;
      @(negedge clk_ext);
      prev = SCLK2;
      start2 = 1'b1;
      for (int c = 1; c <= 100 && lat < 0; c++) begin
         @(negedge clk_ext);
         start2 = 1'b0;
         if (SCLK2 !== prev) begin
            k++;
            if (k > 1 && c - t_last != 2) gap_bad++;
            t_last = c;
         end
         prev = SCLK2;
         if (done2) lat = c;
      end
      chk({tag, "_latency"}, lat, 37);
      chk({tag, "_edges"}, k, 16);
      chk({tag, "_gaps"}, gap_bad, 0);
      chk({tag, "_rx"}, rx2, exp_rx);
      @(negedge clk_ext);
   endtask
   initial begin
      int lat, n_done, t1, t2;
      repeat (2) @(negedge clk_ext);
      chk("rst_csn", CS_n, 1);
      chk("rst_sclk", SCLK, 1);
      chk("rst_mosi", MOSI, 1);
      chk("rst_shift", shift, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rx", rx_data, 0);
      reset_n = 1'b1; start = 1'b1; tx_data = 8'h11;
      @(negedge clk_ext);
      chk("rdy_first_edge_busy", busy, 0);
      @(negedge clk_ext);
      chk("rdy_second_edge_busy", busy, 1);
      start = 1'b0;
      lat = -1;
      for (int c = 0; c < 100 && lat < 0; c++) begin
         @(negedge clk_ext);
         if (done) lat = c;
      end
      chk("rdy_done_seen", lat >= 0, 1);
      @(negedge clk_ext);
      run_xfer("r035", 1'b1, 1'b0, 8'hA5, 8'hB4, 1'b0, 1'b0, 8'h00);
      run_xfer("r036", 1'b0, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h00);
      repeat (3) @(negedge clk_ext);
      chk("r036_idle_sclk", SCLK, 0);
      run_xfer("r040", 1'b0, 1'b0, 8'h81, 8'h5A, 1'b0, 1'b1, 8'h00);
      CPOL = 1'b0; CPHA = 1'b0;
      @(negedge clk_ext);
      start = 1'b1; tx_data = 8'hC3;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_ext);
         start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      chk("r038_csn", CS_n, 1);
      chk("r038_sclk", SCLK, 1);
      chk("r038_busy", busy, 0);
      chk("r038_mosi", MOSI, 1);
      chk("r038_shift", shift, 0);
      chk("r038_rx", rx_data, 0);
      @(negedge clk_ext);
      reset_n = 1'b1;
      n_done = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_ext);
         if (done) n_done++;
      end
      chk("r038_no_done", n_done, 0);
      start = 1'b1; tx_data = 8'h69;
      n_done = 0; t1 = -1; t2 = -1;
      for (int c = 1; c <= 220; c++) begin
         @(negedge clk_ext);
         if (c == 100) start = 1'b0;
         if (done) begin
            n_done++;
            if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
         end
      end
      chk("r037_pulses", n_done, 2);
      chk("r037_first", t1, 73);
      chk("r037_spacing", t2 - t1, 74);
      for (int i = 0; i < 6; i++)
         run_xfer("rand", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1, 8'($urandom));
      run2("r039_pre", 1'b1, 8'hFF);
      run2("r039", 1'b0, 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk_ext cycles per SCLK half-period (legal 2..255).
REQ-002 Parameter: DATA_W, default 8, bits per transfer, MSB first.
REQ-003 clk_ext  input  1  single system clock (50 MHz); all flops on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 CPOL  input  1  SCLK idle level; sampled with start.
REQ-006 CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled with start.
REQ-007 start  input  1  transfer request, honoured only in IDLE.
REQ-008 tx_data  input  DATA_W  byte to transmit; latched with start.
REQ-009 MISO  input  1  serial data from slave.
REQ-010 SCLK  output  1  serial clock to slave and to the receive shift buffer.
REQ-011 MOSI  output  1  serial data to slave.
REQ-012 CS_n  output  1  slave select, active-low.
REQ-013 shift  output  1  high while bits are being clocked; enables the receive shift buffer.
REQ-014 busy  output  1  high from the cycle after start is accepted until done.
REQ-015 done  output  1  one-cycle pulse at transfer end.
REQ-016 rx_data  output  DATA_W  received byte, valid from the done cycle until the next done.

Function
REQ-017 FSM states: IDLE, LEAD, XFER, TRAIL, DONE.
REQ-018 IDLE: start=1 at a clk_ext edge latches tx_data, CPOL, CPHA; next state LEAD; CS_n low and busy high from that edge.
REQ-019 LEAD: lasts CLK_DIV cycles; SCLK = latched CPOL; MOSI = tx_data[DATA_W-1].
REQ-020 XFER: 2*DATA_W half-periods of CLK_DIV cycles each; SCLK toggles at the end of every half-period; shift=1 throughout.
REQ-021 CPHA=0: MISO sampled on odd edges (1,3,...); MOSI advances on even edges, except that no advance occurs after the final edge.
REQ-022 CPHA=1: MOSI advances on odd edges, with the first bit already presented in LEAD; MISO sampled on even edges.
REQ-023 Sampled bits shift into a DATA_W receive register MSB first.
REQ-024 TRAIL: lasts CLK_DIV cycles; SCLK = CPOL; CS_n stays low.
REQ-025 DONE: one cycle; done=1; rx_data loaded; CS_n high; busy low; next state IDLE.
REQ-026 Latency: done asserts exactly (2*DATA_W+2)*CLK_DIV+1 cycles after the start edge, i.e. 73 cycles for the defaults.
REQ-027 start is ignored outside IDLE, including the DONE cycle; back-to-back start in the cycle after DONE is accepted.
REQ-028 Changes to CPOL/CPHA/tx_data mid-transfer have no effect.
REQ-029 IDLE: SCLK follows the CPOL input with one-cycle latency; MOSI=1; shift=0.
REQ-030 Half-period counter wraps from CLK_DIV-1 to 0; the edge counter is sized to hold 2*DATA_W.

Reset
REQ-031 Assertion of reset_n=0, at any time including mid-transfer, immediately forces: state IDLE, CS_n=1, SCLK=1, MOSI=1, shift=0, busy=0, done=0, rx_data=0, all counters 0.
REQ-032 The first start is accepted on the second clk_ext edge after reset_n deasserts.

Structure
REQ-033 Package spi_pkg holds the FSM state enum, the DATA_W default and the CLK_DIV default.
REQ-034 Sub-module spi_clk_gen holds the half-period divider and emits lead_edge/trail_edge strobes plus the next SCLK level.

Verification
REQ-035 Scenario: CPOL=1, CPHA=0, tx_data=0xA5, slave returns 0xB4 -> MOSI bits 1,0,1,0,0,1,0,1; rx_data=0xB4; done at cycle 73.
REQ-036 Scenario: CPOL=0, CPHA=1, tx_data=0x3C, MISO looped to MOSI -> rx_data=0x3C; SCLK idles low.
REQ-037 Scenario: start held high continuously for two transfers -> exactly two done pulses, separated by 74 cycles.
REQ-038 Scenario: reset_n pulsed low at cycle 30 of a transfer -> CS_n=1, SCLK=1, busy=0 within the same cycle; no done pulse.
REQ-039 Scenario: CLK_DIV=2, tx_data=0xFF, MISO=0 -> 16 SCLK edges, each 2 cycles apart; rx_data=0x00; done at cycle 37.
REQ-040 Scenario: tx_data changed to 0x00 mid-transfer of 0x81 -> MOSI still shifts out 0x81.
